// File: rtl/tb_ring_buffer.sv
// Circular traceback buffer: a DEPTH-stage recirculating shift ring holding one
// WIDTH-bit traceback pointer per processing element. Each enabled cycle either
// loads a new pointer at the head or rotates the ring by one stage. A position
// counter with wrap pulse and fill/overflow tracking let the traceback
// controller locate entries without counting cycles itself.
module tb_ring_buffer #(
  parameter int unsigned   WIDTH = 2,
  parameter int unsigned   DEPTH = 256,
  localparam int unsigned  CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] t_in,
  output logic [WIDTH-1:0] t_out,
  output logic [CNT_W-1:0] pos,
  output logic             wrap,
  output logic [CNT_W:0]   fill_cnt,
  output logic             full,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] PosLast  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   FillMax  = (CNT_W + 1)'(DEPTH);

  logic [WIDTH-1:0] ring_q [DEPTH];
  logic [WIDTH-1:0] ring_d [DEPTH];
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W:0]   fill_q, fill_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             full_w;

  assign full_w = (fill_q == FillMax);

  // Next-state: clear beats enable; wrap/ovf are pulses so they default low.
  always_comb begin
    ring_d = ring_q;
    pos_d  = pos_q;
    fill_d = fill_q;
    wrap_d = 1'b0;
    ovf_d  = 1'b0;
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ring_d[i] = '0;
      end
      pos_d  = '0;
      fill_d = '0;
    end else if (en) begin
      // Head takes the new pointer or the tail; on a load while full the tail
      // (oldest pointer) is simply dropped.
      ring_d[0] = valid ? t_in : ring_q[DEPTH-1];
      for (int unsigned i = 1; i < DEPTH; i++) begin
        ring_d[i] = ring_q[i-1];
      end
      // Explicit wrap compare keeps non-power-of-two depths gap-free.
      if (pos_q == PosLast) begin
        pos_d  = '0;
        wrap_d = 1'b1;
      end else begin
        pos_d = pos_q + CNT_W'(1);
      end
      if (valid) begin
        if (full_w) begin
          ovf_d = 1'b1;
        end else begin
          fill_d = fill_q + (CNT_W + 1)'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      pos_q  <= '0;
      fill_q <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ring_q[i] <= ring_d[i];
      end
      pos_q  <= pos_d;
      fill_q <= fill_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign t_out    = ring_q[0];
  assign pos      = pos_q;
  assign wrap     = wrap_q;
  assign fill_cnt = fill_q;
  assign full     = full_w;
  assign ovf      = ovf_q;

endmodule
